alu_sequencer: RTL

Parametrised single-clock successor to the CPU's phase-clocked ALU. It executes the same x86-subset opcode set (push, pop, call, ret, mov, leave, 83-group) as a sequence of 1–3 result phases, driven by an internal phase FSM instead of separate phase clocks. New over the previous generation: a start/valid handshake, configurable width, stack direction and stack scaling, a sign-extended call displacement, zero/carry flags, and illegal-opcode reporting. It sits between the instruction fetch/decode stage and the register-file write-back mux.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_seq_decode.sv | 16 +
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode/ModRM constants, sequencer state type and per-opcode phase counts
package alu_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    localparam logic [7:0] OP_PUSH_BP = 8'h55;
    localparam logic [7:0] OP_PUSH_BX = 8'h53;
    localparam logic [7:0] OP_PUSH_I8 = 8'h6a;
    localparam logic [7:0] OP_MOV     = 8'h89;
    localparam logic [7:0] OP_MOV_I   = 8'hb8;
    localparam logic [7:0] OP_POP     = 8'h5d;
    localparam logic [7:0] OP_RET     = 8'hc3;
    localparam logic [7:0] OP_CALL    = 8'he8;
    localparam logic [7:0] OP_MOV_LD  = 8'h8b;
    localparam logic [7:0] OP_GRP83   = 8'h83;
    localparam logic [7:0] OP_LEAVE   = 8'hc9;
    localparam logic [7:0] MRM_SUB_R  = 8'he8;
    localparam logic [7:0] MRM_ADD_SP = 8'hc4;
    localparam logic [7:0] MRM_SUB_SP = 8'hec;
    localparam logic [7:0] MRM_CMP    = 8'h7d;
    // zero phases marks an opcode/ModRM pair the sequencer cannot execute
    function automatic logic [1:0] phase_count(input logic [7:0] op, input logic [7:0] modrm);
        case (op)
            OP_MOV, OP_MOV_I: return 2'd1;
            OP_PUSH_BP, OP_PUSH_BX, OP_PUSH_I8, OP_POP, OP_RET, OP_MOV_LD: return 2'd2;
            OP_CALL, OP_LEAVE: return 2'd3;
            OP_GRP83: return (modrm == MRM_CMP) ? 2'd2 :
                             (modrm == MRM_SUB_R || modrm == MRM_ADD_SP || modrm == MRM_SUB_SP) ? 2'd1 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: opcode/ModRM to phase count, flag-setting phase and illegal indication
module alu_seq_decode
    import alu_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [7:0] modrm,
    output logic [1:0] n_phases,
    output logic       flag_en,
    output logic [1:0] flag_phase,
    output logic       illegal
);
    assign n_phases   = phase_count(opcode, modrm);
    assign illegal    = n_phases == 2'd0;
    assign flag_en    = opcode == OP_GRP83 && (modrm == MRM_SUB_R || modrm == MRM_CMP);
    assign flag_phase = (modrm == MRM_CMP) ? 2'd1 : 2'd0;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-clock phase sequencer for the x86-subset ALU
// Each result phase is an EXEC (compute from registor_in) followed by a HOLD (strobe).
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STACK_STEP = 1,
    parameter int STACK_DOWN = 0,
    parameter int WORD_SHIFT = 2,
    parameter int CALL_LEN   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      ope,
    input  logic [3:0]       num_of_ope,
    input  logic [WIDTH-1:0] registor_in,
    output logic             busy,
    output logic             result_valid,
    output logic [1:0]       phase,
    output logic             last,
    output logic [WIDTH-1:0] alu_result_bus,
    output logic             zero,
    output logic             carry,
    output logic             illegal
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] LEN  = WIDTH'(CALL_LEN);
    localparam bit GROW_UP = (STACK_DOWN == 0);
    function automatic logic [WIDTH-1:0] stack_adj(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] x,
                                                   input logic up);
        return up ? r + x : r - x;
    endfunction
    state_t state_q, state_d;
    logic [31:0] ope_q, ope_d;
    logic [3:0] num_q, num_d;
    logic [1:0] phase_q, phase_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic zero_q, zero_d, carry_q, carry_d, illegal_q, illegal_d;
    logic [7:0] op, modrm;
    logic [1:0] n_phases, flag_phase;
    logic flag_en, dec_illegal, is_last;
    logic [23:0] imm24;
    logic [WIDTH-1:0] r, d, sub_b, call_ret, exec_res;
    logic [WIDTH:0] diff;
    assign op       = ope_q[31:24];
    assign modrm    = ope_q[23:16];
    assign imm24    = {ope_q[7:0], ope_q[15:8], ope_q[23:16]};
    assign r        = registor_in;
    assign d        = WIDTH'(ope_q[15:8]) >> WORD_SHIFT;
    assign sub_b    = (op == OP_GRP83 && modrm == MRM_CMP) ? WIDTH'(ope_q[7:0]) : WIDTH'(ope_q[15:8]);
    // one extra bit so the top of the difference is the borrow
    assign diff     = {1'b0, r} - {1'b0, sub_b};
    assign call_ret = r + WIDTH'(num_q);
    alu_seq_decode u_decode (
        .opcode    (op),
        .modrm     (modrm),
        .n_phases  (n_phases),
        .flag_en   (flag_en),
        .flag_phase(flag_phase),
        .illegal   (dec_illegal)
    );
    assign is_last = phase_q == n_phases - 2'd1;
    always_comb begin
        exec_res = r;
        case (op)
            OP_PUSH_BP, OP_PUSH_BX: exec_res = (phase_q == 2'd0) ? stack_adj(r, STEP, GROW_UP) : r;
            OP_PUSH_I8: exec_res = (phase_q == 2'd0) ? stack_adj(r, STEP, GROW_UP) : WIDTH'($signed(ope_q[23:16]));
            OP_MOV_I:   exec_res = WIDTH'(imm24);
            OP_POP:     exec_res = (phase_q == 2'd0) ? r : stack_adj(r, STEP, !GROW_UP);
            OP_RET:     exec_res = stack_adj(r, STEP, !GROW_UP);
            OP_CALL:    exec_res = (phase_q == 2'd0) ? stack_adj(r, STEP, GROW_UP) :
                                   (phase_q == 2'd1) ? call_ret : call_ret + WIDTH'($signed(imm24)) - LEN;
            OP_MOV_LD:  exec_res = (phase_q == 2'd0) ? stack_adj(r, d, !GROW_UP) : r;
            OP_GRP83:   exec_res = (modrm == MRM_ADD_SP) ? stack_adj(r, d, !GROW_UP) :
                                   (modrm == MRM_SUB_SP || (modrm == MRM_CMP && phase_q == 2'd0)) ?
                                   stack_adj(r, d, GROW_UP) : diff[WIDTH-1:0];
            OP_LEAVE:   exec_res = (phase_q == 2'd2) ? stack_adj(r, STEP, !GROW_UP) : r;
            default:    exec_res = r;
        endcase
    end
    always_comb begin
        state_d   = state_q;
        ope_d     = ope_q;
        num_d     = num_q;
        phase_d   = phase_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = EXEC;
                ope_d   = ope;
                num_d   = num_of_ope;
                phase_d = 2'd0;
            end
            EXEC: if (dec_illegal) begin
                state_d   = IDLE;
                illegal_d = 1'b1;
            end else begin
                state_d  = HOLD;
                result_d = exec_res;
                zero_d   = (flag_en && phase_q == flag_phase) ? exec_res == '0 : zero_q;
                carry_d  = (flag_en && phase_q == flag_phase) ? diff[WIDTH] : carry_q;
            end
            HOLD: begin
                state_d = is_last ? IDLE : EXEC;
                phase_d = is_last ? 2'd0 : phase_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ope_q     <= '0;
            num_q     <= '0;
            phase_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ope_q     <= ope_d;
            num_q     <= num_d;
            phase_q   <= phase_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end
    assign busy           = state_q != IDLE;
    assign result_valid   = state_q == HOLD;
    assign last           = result_valid && is_last;
    assign phase          = phase_q;
    assign alu_result_bus = result_q;
    assign zero           = zero_q;
    assign carry          = carry_q;
    assign illegal        = illegal_q;
endmodule
